local_prediction_table: RTL and testbench
=========================================

# local_prediction_table

Local prediction table (LPT) for the tournament branch predictor. It consumes the 10-bit local history produced by the local history table and uses it to index 1024 three-bit saturating counters. It returns a registered taken/not-taken prediction and queues each lookup in a small in-flight buffer. When branch outcomes resolve in order, it trains the queued counter and flags mispredictions.

## Interface
Parameters:
- HIST_W, 10, history/index width; table depth is 2**HIST_W
- CTR_W, 3, saturating counter width
- DEPTH, 4, in-flight buffer entries (power of two)

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- hist_valid  in  1  lookup request
- hist_index  in  HIST_W  local history from the LHT
- hist_ready  out  1  lookup accepted when high; equals !full
- pred_valid  out  1  one-cycle pulse, prediction valid
- pred_taken  out  1  counter MSB of the looked-up entry
- pred_count  out  CTR_W  full counter value used for the prediction
- resolve_valid  in  1  oldest outstanding branch resolved
- resolve_taken  in  1  actual outcome
- mispredict  out  1  one-cycle pulse: stored prediction differs from outcome
- resolve_error  out  1  one-cycle pulse: resolve arrived with the buffer empty
- inflight  out  $clog2(DEPTH)+1  current buffer occupancy

## Operation
- Table: 2**HIST_W counters, each CTR_W bits wide, all reset to 0 (strongly not-taken).
- Prediction: taken iff counter MSB = 1.
- Lookup is accepted when hist_valid && hist_ready.
  - The counter is read.
  - {hist_index, predicted bit} is pushed into the in-flight FIFO.
- Resolve with a non-empty FIFO:
  - The head entry is popped.
  - The counter at the head index is incremented if taken, decremented if not taken.
  - Saturating arithmetic: 7 stays 7, 0 stays 0. Width stays CTR_W with no wrap.
  - mispredict is registered as (stored prediction != resolve_taken).
- Resolve with an empty FIFO: table and FIFO are untouched; resolve_error pulses.
- Simultaneous lookup and resolve:
  - Both actions happen.
  - If the lookup index equals the head index, the lookup is write-first: the prediction uses the post-update counter value.
  - Occupancy is unchanged when both push and pop occur.
- Full FIFO: hist_ready = 0 regardless of resolve_valid in the same cycle; there is no combinational ready-from-resolve path.
- FIFO pointers are DEPTH-wrapping. occupancy is held in a separate counter, range 0..DEPTH.
- A lookup presented while hist_ready = 0 is ignored. The requester must hold it.

## Timing
- Reset values:
  - pred_valid = 0, pred_taken = 0, pred_count = 0
  - mispredict = 0, resolve_error = 0
  - inflight = 0, hist_ready = 1
  - all counters = 0, FIFO empty
- Lookup latency is 1 cycle: accepted at edge N, and pred_valid/pred_taken/pred_count are valid after edge N, for exactly one cycle.
- pred_taken and pred_count hold their last value while pred_valid = 0.
- Resolve latency:
  - The counter write occurs at edge M.
  - A lookup accepted at edge M sees the updated value via bypass.
  - mispredict/resolve_error pulse for the cycle after edge M.
- inflight and hist_ready update on the same edge as the push/pop.
- Reset asserted mid-operation immediately:
  - clears the table, FIFO, and all outputs;
  - discards outstanding branches.
  - Resolves after reset deassertion are treated as on an empty buffer.

## Structure
- Shared package bp_pkg holds:
  - HIST_W and CTR_W constants;
  - the CTR_RESET value (0);
  - functions sat_inc/sat_dec;
  - the in-flight entry struct {index, pred}.
- The LHT and the future choice/global tables import the same package.
- One sub-module, bp_inflight_fifo: a parameterised synchronous FIFO with push/pop/full/empty/count and same-cycle push+pop support.
- The table array, bypass, and output registers live in the top level.

## Test plan
- Reset, then lookup index 0x155 -> next cycle pred_valid=1, pred_taken=0, pred_count=0; inflight=1.
- Four lookups at index 0x3FF, then a fifth -> hist_ready=0 after the fourth, fifth ignored, inflight=4. One resolve then frees a slot, hist_ready=1.
- Index 0x00A, eight lookup/resolve-taken pairs -> count sequence 0,1,...,7,7 (saturates).
  - pred_taken first becomes 1 when count reaches 4.
  - mispredict pulses on the first four resolves.
- Count at 7, then resolve not-taken with a same-cycle lookup at the same index -> prediction shows pred_count=6 (bypass).
- Resolve with inflight=0 -> resolve_error pulse, no counter changes, inflight stays 0.
- Two lookups outstanding, assert reset mid-stream -> all outputs 0, inflight=0; a following resolve raises resolve_error; a lookup of the previously trained index returns count 0.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch predictor constants, counter helpers and in-flight entry type
package bp_pkg;

    localparam int HIST_W = 10;
    localparam int CTR_W  = 3;

    localparam logic [CTR_W-1:0] CTR_RESET = '0;

    typedef struct packed {
        logic [HIST_W-1:0] index;
        logic              pred;
    } inflight_entry_t;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

    function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] value);
        return (value == '0) ? value : value - 1'b1;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - parameterised synchronous FIFO with same-cycle push/pop
module bp_inflight_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is not reset; validity is tracked solely by count.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/local_prediction_table.sv
// rtl/local_prediction_table.sv - local history indexed saturating counter table with in-order training
module local_prediction_table #(
    parameter int HIST_W = bp_pkg::HIST_W,
    parameter int CTR_W  = bp_pkg::CTR_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hist_valid,
    input  logic [HIST_W-1:0]        hist_index,
    output logic                     hist_ready,
    output logic                     pred_valid,
    output logic                     pred_taken,
    output logic [CTR_W-1:0]         pred_count,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    output logic                     mispredict,
    output logic                     resolve_error,
    output logic [$clog2(DEPTH):0]   inflight
);

    import bp_pkg::*;

    localparam int TABLE_DEPTH = 2 ** HIST_W;

    logic [CTR_W-1:0] ctr_table [TABLE_DEPTH];

    inflight_entry_t  push_entry;
    inflight_entry_t  head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             lookup;
    logic             resolve_ok;
    logic [CTR_W-1:0] head_count;
    logic [CTR_W-1:0] updated_count;
    logic [CTR_W-1:0] lookup_count;

    assign hist_ready = !fifo_full;
    assign lookup     = hist_valid && hist_ready;
    assign resolve_ok = resolve_valid && !fifo_empty;

    assign head_count    = ctr_table[head_entry.index];
    assign updated_count = resolve_taken ? sat_inc(head_count) : sat_dec(head_count);

    // Write-first: a lookup hitting the entry being trained sees the new value.
    assign lookup_count = (resolve_ok && (hist_index == head_entry.index))
                          ? updated_count : ctr_table[hist_index];

    assign push_entry.index = hist_index;
    assign push_entry.pred  = lookup_count[CTR_W-1];

    bp_inflight_fifo #(
        .W     ($bits(inflight_entry_t)),
        .DEPTH (DEPTH)
    ) u_inflight_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (lookup),
        .push_data (push_entry),
        .pop       (resolve_ok),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (inflight)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                ctr_table[i] <= CTR_RESET;
            end
        end else if (resolve_ok) begin
            ctr_table[head_entry.index] <= updated_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pred_valid    <= 1'b0;
            pred_taken    <= 1'b0;
            pred_count    <= CTR_RESET;
            mispredict    <= 1'b0;
            resolve_error <= 1'b0;
        end else begin
            pred_valid    <= lookup;
            mispredict    <= resolve_ok && (head_entry.pred != resolve_taken);
            resolve_error <= resolve_valid && fifo_empty;
            if (lookup) begin
                pred_taken <= lookup_count[CTR_W-1];
                pred_count <= lookup_count;
            end
        end
    end

endmodule

// File: tb/tb_local_prediction_table.sv
// tb/tb_local_prediction_table.sv - directed self-checking bench for local_prediction_table
module tb_local_prediction_table;

    logic       clock = 1'b0;
    logic       reset;
    logic       hist_valid;
    logic [9:0] hist_index;
    logic       hist_ready;
    logic       pred_valid;
    logic       pred_taken;
    logic [2:0] pred_count;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       mispredict;
    logic       resolve_error;
    logic [2:0] inflight;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    local_prediction_table #(
        .HIST_W (10),
        .CTR_W  (3),
        .DEPTH  (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .hist_valid    (hist_valid),
        .hist_index    (hist_index),
        .hist_ready    (hist_ready),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_count    (pred_count),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .mispredict    (mispredict),
        .resolve_error (resolve_error),
        .inflight      (inflight)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_compared++;
        if (got !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic lookup(input logic [9:0] idx);
        hist_valid = 1'b1;
        hist_index = idx;
        tick();
        hist_valid = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        resolve_valid = 1'b1;
        resolve_taken = taken;
        tick();
        resolve_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        hist_valid    = 1'b0;
        hist_index    = '0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        tick();
        reset = 1'b0;

        check("rst_pred_valid", pred_valid, 0);
        check("rst_pred_count", pred_count, 0);
        check("rst_inflight", inflight, 0);
        check("rst_hist_ready", hist_ready, 1);

        lookup(10'h155);
        check("lk155_valid", pred_valid, 1);
        check("lk155_taken", pred_taken, 0);
        check("lk155_count", pred_count, 0);
        check("lk155_inflight", inflight, 1);
        tick();
        check("pred_valid_pulse", pred_valid, 0);

        do_reset();
        for (int i = 0; i < 4; i++) lookup(10'h3FF);
        check("full_ready", hist_ready, 0);
        check("full_inflight", inflight, 4);
        lookup(10'h3FF);
        check("full_ignored_valid", pred_valid, 0);
        check("full_ignored_inflight", inflight, 4);
        resolve(1'b1);
        check("free_mispredict", mispredict, 1);
        check("free_inflight", inflight, 3);
        check("free_ready", hist_ready, 1);

        do_reset();
        for (int k = 0; k < 8; k++) begin
            lookup(10'h00A);
            check($sformatf("sat_count_%0d", k), pred_count, k);
            check($sformatf("sat_taken_%0d", k), pred_taken, (k >= 4) ? 1 : 0);
            resolve(1'b1);
            check($sformatf("sat_mispredict_%0d", k), mispredict, (k < 4) ? 1 : 0);
        end
        lookup(10'h00A);
        check("sat_count_8", pred_count, 7);
        check("sat_taken_8", pred_taken, 1);

        hist_valid    = 1'b1;
        hist_index    = 10'h00A;
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        tick();
        hist_valid    = 1'b0;
        resolve_valid = 1'b0;
        check("bypass_valid", pred_valid, 1);
        check("bypass_count", pred_count, 6);
        check("bypass_taken", pred_taken, 1);
        check("bypass_mispredict", mispredict, 1);
        check("bypass_inflight", inflight, 1);

        resolve(1'b1);
        check("drain_mispredict", mispredict, 0);
        check("drain_inflight", inflight, 0);
        resolve(1'b0);
        check("empty_resolve_error", resolve_error, 1);
        check("empty_mispredict", mispredict, 0);
        check("empty_inflight", inflight, 0);
        tick();
        check("resolve_error_pulse", resolve_error, 0);
        lookup(10'h00A);
        check("empty_no_change", pred_count, 7);
        resolve(1'b1);

        lookup(10'h00A);
        lookup(10'h00A);
        check("pre_reset_inflight", inflight, 2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_pred_valid", pred_valid, 0);
        check("mid_rst_pred_taken", pred_taken, 0);
        check("mid_rst_pred_count", pred_count, 0);
        check("mid_rst_inflight", inflight, 0);
        check("mid_rst_ready", hist_ready, 1);
        tick();
        reset = 1'b0;
        resolve(1'b1);
        check("post_rst_resolve_error", resolve_error, 1);
        check("post_rst_mispredict", mispredict, 0);
        lookup(10'h00A);
        check("post_rst_count", pred_count, 0);
        check("post_rst_taken", pred_taken, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
